// File: rtl/decode_stage_p.sv
// decode_stage_p
// Parametrised MIPS instruction-decode stage: register file, hazard detection,
// early beq resolution and the ID/EX pipeline register.
//
// Parameters
//   XLEN  datapath width (32 or 64)
//   NREG  register count (16 or 32); index = low $clog2(NREG) bits of a field
//
// Ports
//   clock, reset_n               rising-edge clock, asynchronous active-low reset
//   if_pc_plus_4, if_inst        PC+4 and instruction currently in ID
//   if_valid                     ID holds a real instruction
//   mem_regwrite, mem_memread    control of the instruction in MEM
//   mem_rd, mem_result           destination / ALU result of the instruction in MEM
//   wb_regwrite, wb_rd, wb_data  register-file write port from WB
//   pc_write, ifid_write         low while stalling
//   ifid_flush, branch_taken     high when the beq in ID is taken
//   branch_target                PC+4 + (imm << 2)
//   ex_*                         registered ID/EX outputs
//   stall_cnt                    saturating count of stall cycles
//
// Optional feature: define DECODE_BRANCH_FWD_EN to add a MEM-to-comparator
// forwarding path for beq, removing the MEM-stage ALU dependency stall.

module decode_stage_p #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic [XLEN-1:0] if_pc_plus_4,
   input  logic [31:0]     if_inst,
   input  logic            if_valid,
   input  logic            mem_regwrite,
   input  logic            mem_memread,
   input  logic [4:0]      mem_rd,
   input  logic [XLEN-1:0] mem_result,
   input  logic            wb_regwrite,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            pc_write,
   output logic            ifid_write,
   output logic            ifid_flush,
   output logic            branch_taken,
   output logic [XLEN-1:0] branch_target,
   output logic            ex_valid,
   output logic [1:0]      ex_wb,
   output logic [2:0]      ex_m,
   output logic [3:0]      ex_ex,
   output logic [4:0]      ex_rs,
   output logic [4:0]      ex_rt,
   output logic [4:0]      ex_rd,
   output logic [XLEN-1:0] ex_data_a,
   output logic [XLEN-1:0] ex_data_b,
   output logic [XLEN-1:0] ex_imm,
   output logic [4:0]      ex_shamt,
   output logic [15:0]     stall_cnt
);

   localparam int IW = $clog2(NREG);

   logic [XLEN-1:0] rf_q [NREG];
   logic [XLEN-1:0] rf_d [NREG];

   logic            ex_valid_q, ex_valid_d;
   logic [1:0]      ex_wb_q, ex_wb_d;
   logic [2:0]      ex_m_q, ex_m_d;
   logic [3:0]      ex_ex_q, ex_ex_d;
   logic [4:0]      ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d, ex_rd_q, ex_rd_d;
   logic [XLEN-1:0] ex_data_a_q, ex_data_a_d, ex_data_b_q, ex_data_b_d;
   logic [XLEN-1:0] ex_imm_q, ex_imm_d;
   logic [4:0]      ex_shamt_q, ex_shamt_d;
   logic [15:0]     stall_cnt_q, stall_cnt_d;

   logic [5:0]      opcode, funct;
   logic [IW-1:0]   rs_idx, rt_idx, ex_dest_idx, mem_idx, wb_idx;
   logic            is_r, is_lw, is_sw, is_beq, is_addi, is_sll, id_valid, beq_id;
   logic            use_rs, use_rt, match_ex, match_mem, stall;
   logic [1:0]      wb_c;
   logic [2:0]      m_c;
   logic [3:0]      ex_c;
   logic [XLEN-1:0] rd_rs, rd_rt, cmp_a, cmp_b, imm_ext;

   // Field extraction and opcode classification
   always_comb begin
      opcode   = if_inst[31:26];
      funct    = if_inst[5:0];
      rs_idx   = if_inst[21 +: IW];
      rt_idx   = if_inst[16 +: IW];
      mem_idx  = mem_rd[IW-1:0];
      wb_idx   = wb_rd[IW-1:0];
      is_r     = (opcode == 6'h00);
      is_lw    = (opcode == 6'h23);
      is_sw    = (opcode == 6'h2B);
      is_beq   = (opcode == 6'h04);
      is_addi  = (opcode == 6'h08);
      id_valid = if_valid & (is_r | is_lw | is_sw | is_beq | is_addi);
      is_sll   = id_valid & is_r & (funct == 6'h00);
      beq_id   = id_valid & is_beq;
      imm_ext  = {{(XLEN-16){if_inst[15]}}, if_inst[15:0]};
   end

   // Main control decoder: wb = {MemtoReg, RegWrite},
   // m = {Branch, MemWrite, MemRead}, ex = {ALUSrc, ALUOp, RegDst}
   always_comb begin
      wb_c = 2'b00;
      m_c  = 3'b000;
      ex_c = 4'b0000;
      if (id_valid) begin
         if (is_r) begin
            wb_c = 2'b01;
            ex_c = 4'b0101;
         end else if (is_lw) begin
            wb_c = 2'b11;
            m_c  = 3'b001;
            ex_c = 4'b1000;
         end else if (is_sw) begin
            m_c  = 3'b010;
            ex_c = 4'b1000;
         end else if (is_beq) begin
            m_c  = 3'b100;
            ex_c = 4'b0010;
         end else begin
            wb_c = 2'b01;
            ex_c = 4'b1000;
         end
      end
   end

   // Register file write: r0 is never written so it always reads zero
   always_comb begin
      rf_d = rf_q;
      if (wb_regwrite && (wb_idx != '0)) begin
         rf_d[wb_idx] = wb_data;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREG; i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         rf_q <= rf_d;
      end
   end

   // Register reads with write-first bypass from WB, then optional MEM
   // forwarding into the branch comparator only
   always_comb begin
      rd_rs = (wb_regwrite && (wb_idx == rs_idx) && (rs_idx != '0)) ? wb_data : rf_q[rs_idx];
      rd_rt = (wb_regwrite && (wb_idx == rt_idx) && (rt_idx != '0)) ? wb_data : rf_q[rt_idx];
      cmp_a = rd_rs;
      cmp_b = rd_rt;
`ifdef DECODE_BRANCH_FWD_EN
      if (mem_regwrite && !mem_memread && (mem_idx == rs_idx) && (rs_idx != '0)) begin
         cmp_a = mem_result;
      end
      if (mem_regwrite && !mem_memread && (mem_idx == rt_idx) && (rt_idx != '0)) begin
         cmp_b = mem_result;
      end
`endif
   end

   // Hazard detection; sll takes its only source from rt
   always_comb begin
      ex_dest_idx = ex_ex_q[0] ? ex_rd_q[IW-1:0] : ex_rt_q[IW-1:0];
      use_rs      = id_valid & ~is_sll & (rs_idx != '0);
      use_rt      = id_valid & (is_r | is_sw | is_beq) & (rt_idx != '0);
      match_ex    = (use_rs && (rs_idx == ex_dest_idx)) || (use_rt && (rt_idx == ex_dest_idx));
      match_mem   = (use_rs && (rs_idx == mem_idx)) || (use_rt && (rt_idx == mem_idx));
      stall       = (ex_m_q[0] & match_ex)
                  | (beq_id & ex_wb_q[0] & match_ex)
                  | (beq_id & mem_memread & match_mem);
`ifndef DECODE_BRANCH_FWD_EN
      stall       = stall | (beq_id & mem_regwrite & ~mem_memread & match_mem);
`endif
   end

   // Stall beats branch resolution; a stalled or invalid slot becomes a bubble
   always_comb begin
      pc_write      = ~stall;
      ifid_write    = ~stall;
      branch_taken  = beq_id & ~stall & (cmp_a == cmp_b);
      ifid_flush    = branch_taken;
      branch_target = if_pc_plus_4 + (imm_ext << 2);

      ex_valid_d  = 1'b0;
      ex_wb_d     = '0;
      ex_m_d      = '0;
      ex_ex_d     = '0;
      ex_rs_d     = '0;
      ex_rt_d     = '0;
      ex_rd_d     = '0;
      ex_data_a_d = '0;
      ex_data_b_d = '0;
      ex_imm_d    = '0;
      ex_shamt_d  = '0;
      if (id_valid && !stall) begin
         ex_valid_d  = 1'b1;
         ex_wb_d     = wb_c;
         ex_m_d      = m_c;
         ex_ex_d     = ex_c;
         ex_rs_d     = if_inst[25:21];
         ex_rt_d     = if_inst[20:16];
         ex_rd_d     = if_inst[15:11];
         ex_data_a_d = is_sll ? rd_rt : rd_rs;
         ex_data_b_d = rd_rt;
         ex_imm_d    = imm_ext;
         ex_shamt_d  = if_inst[10:6];
      end
      stall_cnt_d = (stall && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1 : stall_cnt_q;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ex_valid_q  <= 1'b0;
         ex_wb_q     <= '0;
         ex_m_q      <= '0;
         ex_ex_q     <= '0;
         ex_rs_q     <= '0;
         ex_rt_q     <= '0;
         ex_rd_q     <= '0;
         ex_data_a_q <= '0;
         ex_data_b_q <= '0;
         ex_imm_q    <= '0;
         ex_shamt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         ex_valid_q  <= ex_valid_d;
         ex_wb_q     <= ex_wb_d;
         ex_m_q      <= ex_m_d;
         ex_ex_q     <= ex_ex_d;
         ex_rs_q     <= ex_rs_d;
         ex_rt_q     <= ex_rt_d;
         ex_rd_q     <= ex_rd_d;
         ex_data_a_q <= ex_data_a_d;
         ex_data_b_q <= ex_data_b_d;
         ex_imm_q    <= ex_imm_d;
         ex_shamt_q  <= ex_shamt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign ex_valid  = ex_valid_q;
   assign ex_wb     = ex_wb_q;
   assign ex_m      = ex_m_q;
   assign ex_ex     = ex_ex_q;
   assign ex_rs     = ex_rs_q;
   assign ex_rt     = ex_rt_q;
   assign ex_rd     = ex_rd_q;
   assign ex_data_a = ex_data_a_q;
   assign ex_data_b = ex_data_b_q;
   assign ex_imm    = ex_imm_q;
   assign ex_shamt  = ex_shamt_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage_p.sv
// Testbench for decode_stage_p: a default 32-bit/32-register instance and a
// 64-bit/16-register instance sharing clock, reset and control inputs.
module tb_decode_stage_p;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [31:0] if_pc_plus_4, if_inst;
   logic        if_valid, mem_regwrite, mem_memread, wb_regwrite;
   logic [4:0]  mem_rd, wb_rd;
   logic [31:0] mem_result, wb_data;
   logic        pc_write, ifid_write, ifid_flush, branch_taken;
   logic [31:0] branch_target;
   logic        ex_valid;
   logic [1:0]  ex_wb;
   logic [2:0]  ex_m;
   logic [3:0]  ex_ex;
   logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
   logic [31:0] ex_data_a, ex_data_b, ex_imm;
   logic [15:0] stall_cnt;

   logic [63:0] w_pc, w_mem_result, w_wb_data;
   logic        w_pc_write, w_ifid_write, w_ifid_flush, w_branch_taken;
   logic [63:0] w_branch_target;
   logic        w_ex_valid;
   logic [1:0]  w_ex_wb;
   logic [2:0]  w_ex_m;
   logic [3:0]  w_ex_ex;
   logic [4:0]  w_ex_rs, w_ex_rt, w_ex_rd, w_ex_shamt;
   logic [63:0] w_ex_data_a, w_ex_data_b, w_ex_imm;
   logic [15:0] w_stall_cnt;

   int total = 0;
   int bad = 0;
   int exp_stalls = 0;

   always #5 clock = ~clock;

   decode_stage_p dut (
      .clock(clock), .reset_n(reset_n), .if_pc_plus_4(if_pc_plus_4), .if_inst(if_inst),
      .if_valid(if_valid), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
      .mem_rd(mem_rd), .mem_result(mem_result), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
      .wb_data(wb_data), .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .branch_taken(branch_taken), .branch_target(branch_target), .ex_valid(ex_valid),
      .ex_wb(ex_wb), .ex_m(ex_m), .ex_ex(ex_ex), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
      .ex_data_a(ex_data_a), .ex_data_b(ex_data_b), .ex_imm(ex_imm), .ex_shamt(ex_shamt),
      .stall_cnt(stall_cnt)
   );

   decode_stage_p #(.XLEN(64), .NREG(16)) dut_w (
      .clock(clock), .reset_n(reset_n), .if_pc_plus_4(w_pc), .if_inst(if_inst),
      .if_valid(if_valid), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
      .mem_rd(mem_rd), .mem_result(w_mem_result), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
      .wb_data(w_wb_data), .pc_write(w_pc_write), .ifid_write(w_ifid_write),
      .ifid_flush(w_ifid_flush), .branch_taken(w_branch_taken), .branch_target(w_branch_target),
      .ex_valid(w_ex_valid), .ex_wb(w_ex_wb), .ex_m(w_ex_m), .ex_ex(w_ex_ex), .ex_rs(w_ex_rs),
      .ex_rt(w_ex_rt), .ex_rd(w_ex_rd), .ex_data_a(w_ex_data_a), .ex_data_b(w_ex_data_b),
      .ex_imm(w_ex_imm), .ex_shamt(w_ex_shamt), .stall_cnt(w_stall_cnt)
   );

   function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int sh, input logic [5:0] fn);
      return {6'h00, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
      return {op, rs[4:0], rt[4:0], imm};
   endfunction

   // Advance to just after the next rising edge
   task tick;
      @(posedge clock);
      #1;
   endtask

   // Empty the pipeline inputs and let two bubbles flow through EX
   task idle;
      if_valid = 0; if_inst = '0; if_pc_plus_4 = '0; w_pc = '0;
      mem_regwrite = 0; mem_memread = 0; mem_rd = '0; mem_result = '0; w_mem_result = '0;
      wb_regwrite = 0; wb_rd = '0; wb_data = '0; w_wb_data = '0;
      tick; tick;
   endtask

   task wb_write(input int rd, input logic [31:0] val);
      if_valid = 0; wb_regwrite = 1; wb_rd = rd[4:0]; wb_data = val;
      tick;
      wb_regwrite = 0; wb_rd = '0; wb_data = '0;
   endtask

   task test_reset;
      idle;
      wb_write(7, 32'h55);
      if_valid = 1; if_inst = itype(6'h23, 7, 2, 16'd8);
      tick;
      if_inst = rtype(2, 4, 3, 0, 6'h20);
      tick;
      total++; if (stall_cnt !== 16'd1) begin bad++; $display("[TB] FAIL rst_pre_stall: got %0d want 1", stall_cnt); end
      if_inst = itype(6'h23, 7, 2, 16'd8);
      tick;
      #2 reset_n = 0;
      #1;
      total++;
      if ({ex_valid, ex_wb, ex_m, ex_ex, ex_rs, ex_rt, ex_rd, ex_data_a, ex_data_b, ex_imm, ex_shamt} !== '0) begin
         bad++; $display("[TB] FAIL rst_ex_zero: got valid=%0b m=%0h a=%0h imm=%0h want all 0", ex_valid, ex_m, ex_data_a, ex_imm);
      end
      total++; if (stall_cnt !== 16'd0) begin bad++; $display("[TB] FAIL rst_stall_cnt: got %0d want 0", stall_cnt); end
      total++; if ({pc_write, ifid_write} !== 2'b11) begin bad++; $display("[TB] FAIL rst_pc_write: got %0b want 11", {pc_write, ifid_write}); end
      @(posedge clock); #1;
      total++; if (ex_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_hold_valid: got %0b want 0", ex_valid); end
      @(negedge clock);
      reset_n = 1;
      wb_regwrite = 1; wb_rd = 5; wb_data = 32'h1234;
      if_valid = 1; if_inst = rtype(5, 0, 6, 0, 6'h20);
      tick;
      total++; if (ex_data_a !== 32'h1234) begin bad++; $display("[TB] FAIL rst_bypass_a: got %0h want 1234", ex_data_a); end
      total++; if ({ex_valid, ex_wb, ex_ex} !== 7'b1_01_0101) begin bad++; $display("[TB] FAIL rst_add_ctrl: got %0b want 1010101", {ex_valid, ex_wb, ex_ex}); end
      wb_regwrite = 0; wb_rd = '0; wb_data = '0;
      if_inst = rtype(7, 5, 8, 0, 6'h20);
      tick;
      total++; if (ex_data_a !== 32'h0) begin bad++; $display("[TB] FAIL rst_rf_cleared: got %0h want 0", ex_data_a); end
      total++; if (ex_data_b !== 32'h1234) begin bad++; $display("[TB] FAIL rst_rf_written: got %0h want 1234", ex_data_b); end
   endtask

   task test_load_use;
      idle;
      if_valid = 1; if_inst = itype(6'h23, 1, 2, 16'd0);
      tick;
      if_inst = rtype(2, 4, 3, 0, 6'h20);
      @(negedge clock);
      total++; if ({pc_write, ifid_write} !== 2'b00) begin bad++; $display("[TB] FAIL lu_stall: got %0b want 00", {pc_write, ifid_write}); end
      tick;
      exp_stalls += 1;
      total++; if (ex_valid !== 1'b0 || ex_wb !== 2'b00) begin bad++; $display("[TB] FAIL lu_bubble: got valid=%0b wb=%0b want 0 00", ex_valid, ex_wb); end
      total++; if (stall_cnt !== exp_stalls[15:0]) begin bad++; $display("[TB] FAIL lu_stall_cnt: got %0d want %0d", stall_cnt, exp_stalls); end
      mem_regwrite = 1; mem_memread = 1; mem_rd = 2;
      @(negedge clock);
      total++; if (pc_write !== 1'b1) begin bad++; $display("[TB] FAIL lu_release: got %0b want 1", pc_write); end
      tick;
      total++; if ({ex_valid, ex_rd, ex_ex} !== {1'b1, 5'd3, 4'h5}) begin bad++; $display("[TB] FAIL lu_issue: got v=%0b rd=%0d ex=%0h want 1 3 5", ex_valid, ex_rd, ex_ex); end
   endtask

   task test_branch_taken;
      idle;
      wb_write(1, 32'd7);
      wb_write(2, 32'd7);
      if_valid = 1; if_pc_plus_4 = 32'h100; if_inst = itype(6'h04, 1, 2, 16'd3);
      @(negedge clock);
      total++; if ({branch_taken, ifid_flush, pc_write} !== 3'b111) begin bad++; $display("[TB] FAIL bt_taken: got %0b want 111", {branch_taken, ifid_flush, pc_write}); end
      total++; if (branch_target !== 32'h10C) begin bad++; $display("[TB] FAIL bt_target: got %0h want 10c", branch_target); end
      if_inst = itype(6'h04, 1, 3, 16'd3);
      #1;
      total++; if ({branch_taken, ifid_flush} !== 2'b00) begin bad++; $display("[TB] FAIL bt_not_taken: got %0b want 00", {branch_taken, ifid_flush}); end
      tick;
      total++; if ({ex_valid, ex_m, ex_ex} !== {1'b1, 3'b100, 4'b0010}) begin bad++; $display("[TB] FAIL bt_ex_ctrl: got m=%0b ex=%0b want 100 0010", ex_m, ex_ex); end
   endtask

   task test_load_branch;
      idle;
      wb_write(1, 32'd3);
      if_valid = 1; if_inst = itype(6'h23, 0, 1, 16'd0);
      tick;
      if_pc_plus_4 = 32'h200; if_inst = itype(6'h04, 1, 2, 16'd4);
      @(negedge clock);
      total++; if ({pc_write, branch_taken} !== 2'b00) begin bad++; $display("[TB] FAIL lb_stall1: got %0b want 00", {pc_write, branch_taken}); end
      tick;
      total++; if (ex_valid !== 1'b0) begin bad++; $display("[TB] FAIL lb_bubble1: got %0b want 0", ex_valid); end
      mem_regwrite = 1; mem_memread = 1; mem_rd = 1;
      @(negedge clock);
      total++; if ({pc_write, branch_taken} !== 2'b00) begin bad++; $display("[TB] FAIL lb_stall2: got %0b want 00", {pc_write, branch_taken}); end
      tick;
      exp_stalls += 2;
      total++; if (stall_cnt !== exp_stalls[15:0]) begin bad++; $display("[TB] FAIL lb_stall_cnt: got %0d want %0d", stall_cnt, exp_stalls); end
      mem_regwrite = 0; mem_memread = 0; mem_rd = '0;
      wb_regwrite = 1; wb_rd = 1; wb_data = 32'd7;
      @(negedge clock);
      total++; if ({pc_write, branch_taken} !== 2'b11) begin bad++; $display("[TB] FAIL lb_resolve: got %0b want 11", {pc_write, branch_taken}); end
      total++; if (branch_target !== 32'h210) begin bad++; $display("[TB] FAIL lb_target: got %0h want 210", branch_target); end
      tick;
   endtask

   task test_alu_branch;
      idle;
      wb_write(2, 32'd5);
      if_valid = 1; if_inst = itype(6'h08, 0, 1, 16'd5);
      tick;
      if_pc_plus_4 = 32'h300; if_inst = itype(6'h04, 1, 2, 16'd2);
      @(negedge clock);
      total++; if (pc_write !== 1'b0) begin bad++; $display("[TB] FAIL ab_stall1: got %0b want 0", pc_write); end
      tick;
      mem_regwrite = 1; mem_rd = 1; mem_result = 32'd5;
      @(negedge clock);
`ifdef DECODE_BRANCH_FWD_EN
      total++; if ({pc_write, branch_taken} !== 2'b11) begin bad++; $display("[TB] FAIL ab_fwd_taken: got %0b want 11", {pc_write, branch_taken}); end
      tick;
      exp_stalls += 1;
`else
      total++; if ({pc_write, branch_taken} !== 2'b00) begin bad++; $display("[TB] FAIL ab_stall2: got %0b want 00", {pc_write, branch_taken}); end
      tick;
      mem_regwrite = 0; mem_rd = '0; mem_result = '0;
      wb_regwrite = 1; wb_rd = 1; wb_data = 32'd5;
      @(negedge clock);
      total++; if ({pc_write, branch_taken} !== 2'b11) begin bad++; $display("[TB] FAIL ab_taken: got %0b want 11", {pc_write, branch_taken}); end
      tick;
      exp_stalls += 2;
`endif
      total++; if (branch_target !== 32'h308 && 1'b1 == if_valid) begin bad++; $display("[TB] FAIL ab_target: got %0h want 308", branch_target); end
      total++; if (stall_cnt !== exp_stalls[15:0]) begin bad++; $display("[TB] FAIL ab_stall_cnt: got %0d want %0d", stall_cnt, exp_stalls); end
   endtask

   task test_sll_decode;
      idle;
      wb_write(9, 32'h11);
      if_valid = 1; if_inst = itype(6'h23, 0, 2, 16'd0);
      tick;
      if_inst = rtype(2, 9, 10, 3, 6'h00);
      @(negedge clock);
      total++; if (pc_write !== 1'b1) begin bad++; $display("[TB] FAIL sll_no_rs_hazard: got %0b want 1", pc_write); end
      tick;
      total++; if ({ex_valid, ex_data_a, ex_shamt} !== {1'b1, 32'h11, 5'd3}) begin bad++; $display("[TB] FAIL sll_ex: got v=%0b a=%0h sh=%0d want 1 11 3", ex_valid, ex_data_a, ex_shamt); end
      if_inst = itype(6'h0D, 9, 1, 16'd1);
      tick;
      total++; if ({ex_valid, ex_wb, ex_m, ex_ex} !== '0) begin bad++; $display("[TB] FAIL bad_opcode: got v=%0b wb=%0b want 0 00", ex_valid, ex_wb); end
   endtask

   task test_width;
      idle;
      if_valid = 0; wb_regwrite = 1; wb_rd = 1; w_wb_data = 64'hAB;
      tick;
      wb_regwrite = 0; wb_rd = '0; w_wb_data = '0;
      if_valid = 1; if_inst = itype(6'h08, 17, 2, 16'hFFFF);
      tick;
      total++; if (w_ex_imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("[TB] FAIL w_imm: got %0h want ffffffffffffffff", w_ex_imm); end
      total++; if ({w_ex_valid, w_ex_data_a} !== {1'b1, 64'hAB}) begin bad++; $display("[TB] FAIL w_alias_r17: got v=%0b a=%0h want 1 ab", w_ex_valid, w_ex_data_a); end
      w_pc = 64'h1000; if_inst = itype(6'h04, 17, 1, 16'hFFFF);
      @(negedge clock);
      total++; if (w_branch_taken !== 1'b1) begin bad++; $display("[TB] FAIL w_taken: got %0b want 1", w_branch_taken); end
      total++; if (w_branch_target !== 64'hFFC) begin bad++; $display("[TB] FAIL w_target: got %0h want ffc", w_branch_target); end
      tick;
   endtask

   initial begin
      reset_n = 0;
      if_valid = 0; if_inst = '0; if_pc_plus_4 = '0; w_pc = '0;
      mem_regwrite = 0; mem_memread = 0; mem_rd = '0; mem_result = '0; w_mem_result = '0;
      wb_regwrite = 0; wb_rd = '0; wb_data = '0; w_wb_data = '0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1;
      test_reset;
      test_load_use;
      test_branch_taken;
      test_load_branch;
      test_alu_branch;
      test_sll_decode;
      test_width;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
